// File: rtl/char_writer.sv
// Terminal write engine: turns a byte stream into character-buffer writes, tracks the cursor, scrolls.
// Optional CHAR_WRITER_FF_CLEAR_EN: form feed (0x0C) clears the whole buffer and homes the cursor.
//
// state  | meaning
// IDLE   | ready for the next byte
// WRITE  | one-cycle printable write, cursor advance and line-wrap
// CLEAR  | blank-fill one recycled row, 64 writes
// CLRALL | blank-fill all 1024 cells (form feed build only)
module char_writer #(
  parameter logic [7:0] BLANK_CHAR = 8'h20
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] in_data,
  input  logic       in_valid,
  output logic       in_ready,
  output logic [9:0] buf_addr,
  output logic [7:0] buf_din,
  output logic       buf_we,
  output logic [5:0] cursor_x,
  output logic [3:0] cursor_y,
  output logic [3:0] first_line,
  output logic       busy
);

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] WRITE  = 2'd1;
  localparam logic [1:0] CLEAR  = 2'd2;
`ifdef CHAR_WRITER_FF_CLEAR_EN
  localparam logic [1:0] CLRALL = 2'd3;
`endif

  logic [1:0] state;
  logic [3:0] phys_row;

  assign phys_row = first_line + cursor_y;
  assign in_ready = (state == IDLE);
  assign busy     = ~in_ready;

  // The clear counter is buf_addr itself; the recycled row sits in buf_addr[9:6].
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      buf_addr   <= 10'd0;
      buf_din    <= 8'd0;
      buf_we     <= 1'b0;
      cursor_x   <= 6'd0;
      cursor_y   <= 4'd0;
      first_line <= 4'd0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            if (in_data >= 8'h20 && in_data <= 8'h7E) begin
              buf_addr <= {phys_row, cursor_x};
              buf_din  <= in_data;
              buf_we   <= 1'b1;
              state    <= WRITE;
            end else begin
              case (in_data)
                8'h0D: cursor_x <= 6'd0;
                8'h0A: begin
                  if (cursor_y != 4'd15) begin
                    cursor_y <= cursor_y + 4'd1;
                  end else begin
                    first_line <= first_line + 4'd1;
                    buf_addr   <= {first_line, 6'd0};
                    buf_din    <= BLANK_CHAR;
                    buf_we     <= 1'b1;
                    state      <= CLEAR;
                  end
                end
                8'h08: begin
                  if (cursor_x != 6'd0) cursor_x <= cursor_x - 6'd1;
                end
`ifdef CHAR_WRITER_FF_CLEAR_EN
                8'h0C: begin
                  cursor_x   <= 6'd0;
                  cursor_y   <= 4'd0;
                  first_line <= 4'd0;
                  buf_addr   <= 10'd0;
                  buf_din    <= BLANK_CHAR;
                  buf_we     <= 1'b1;
                  state      <= CLRALL;
                end
`endif
                default: ;
              endcase
            end
          end
        end
        WRITE: begin
          if (cursor_x == 6'd63) begin
            cursor_x <= 6'd0;
            if (cursor_y != 4'd15) begin
              cursor_y <= cursor_y + 4'd1;
              buf_we   <= 1'b0;
              state    <= IDLE;
            end else begin
              // Wrap on the bottom row scrolls straight into the row clear.
              first_line <= first_line + 4'd1;
              buf_addr   <= {first_line, 6'd0};
              buf_din    <= BLANK_CHAR;
              buf_we     <= 1'b1;
              state      <= CLEAR;
            end
          end else begin
            cursor_x <= cursor_x + 6'd1;
            buf_we   <= 1'b0;
            state    <= IDLE;
          end
        end
        CLEAR: begin
          if (buf_addr[5:0] == 6'd63) begin
            buf_we <= 1'b0;
            state  <= IDLE;
          end else begin
            buf_addr[5:0] <= buf_addr[5:0] + 6'd1;
          end
        end
`ifdef CHAR_WRITER_FF_CLEAR_EN
        CLRALL: begin
          if (buf_addr == 10'd1023) begin
            buf_we <= 1'b0;
            state  <= IDLE;
          end else begin
            buf_addr <= buf_addr + 10'd1;
          end
        end
`endif
        default: begin
          buf_we <= 1'b0;
          state  <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_char_writer.sv
// Directed bench for char_writer: vector table for single-byte behaviour, hand sequences for wrap/scroll/reset.
module tb_char_writer;

  logic       clk;
  logic       rst_n;
  logic [7:0] in_data;
  logic       in_valid;
  logic       in_ready;
  logic [9:0] buf_addr;
  logic [7:0] buf_din;
  logic       buf_we;
  logic [5:0] cursor_x;
  logic [3:0] cursor_y;
  logic [3:0] first_line;
  logic       busy;

  int n_tests = 0;
  int n_fail  = 0;

  char_writer dut (
    .clk(clk), .rst_n(rst_n), .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
    .buf_addr(buf_addr), .buf_din(buf_din), .buf_we(buf_we), .cursor_x(cursor_x),
    .cursor_y(cursor_y), .first_line(first_line), .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] data;
    logic       we;
    logic [9:0] addr;
    logic [7:0] din;
    logic [5:0] x;
    logic [3:0] y;
  } vec_t;

  vec_t vecs[12];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic wait_idle(output int cycles);
    cycles = 0;
    while (!in_ready && cycles < 3000) begin
      @(posedge clk); #1;
      cycles++;
    end
    if (!in_ready) check("idle_timeout", 32'(in_ready), 32'd1);
  endtask

  // Returns one step after the accepting edge, so registered outputs reflect the accepted byte.
  task automatic send(input logic [7:0] d);
    int c;
    wait_idle(c);
    in_data  = d;
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic send_idle(input logic [7:0] d);
    int c;
    send(d);
    wait_idle(c);
  endtask

  task automatic check_clear(input logic [3:0] row);
    for (int i = 0; i < 64; i++) begin
      check("clr_we", 32'(buf_we), 32'd1);
      check("clr_addr", 32'(buf_addr), 32'({row, 6'(i)}));
      check("clr_din", 32'(buf_din), 32'h20);
      check("clr_ready", 32'(in_ready), 32'd0);
      @(posedge clk); #1;
    end
    check("clr_end_we", 32'(buf_we), 32'd0);
    check("clr_end_ready", 32'(in_ready), 32'd1);
  endtask

  initial begin
    int cyc, acc, wes;
    logic [9:0] last;

    vecs[0]  = '{8'h41, 1'b1, 10'h000, 8'h41, 6'd1, 4'd0};
    vecs[1]  = '{8'h0D, 1'b0, 10'h000, 8'h00, 6'd0, 4'd0};
    vecs[2]  = '{8'h0A, 1'b0, 10'h000, 8'h00, 6'd0, 4'd1};
    vecs[3]  = '{8'h43, 1'b1, 10'h040, 8'h43, 6'd1, 4'd1};
    vecs[4]  = '{8'h44, 1'b1, 10'h041, 8'h44, 6'd2, 4'd1};
    vecs[5]  = '{8'h08, 1'b0, 10'h000, 8'h00, 6'd1, 4'd1};
    vecs[6]  = '{8'h08, 1'b0, 10'h000, 8'h00, 6'd0, 4'd1};
    vecs[7]  = '{8'h08, 1'b0, 10'h000, 8'h00, 6'd0, 4'd1};
    vecs[8]  = '{8'h01, 1'b0, 10'h000, 8'h00, 6'd0, 4'd1};
    vecs[9]  = '{8'h7E, 1'b1, 10'h040, 8'h7E, 6'd1, 4'd1};
    vecs[10] = '{8'h7F, 1'b0, 10'h000, 8'h00, 6'd1, 4'd1};
    vecs[11] = '{8'h1F, 1'b0, 10'h000, 8'h00, 6'd1, 4'd1};

    rst_n = 1'b0; in_valid = 1'b0; in_data = 8'h00;
    #23 rst_n = 1'b1;
    @(posedge clk); #1;
    check("rst_we", 32'(buf_we), 32'd0);
    check("rst_addr", 32'(buf_addr), 32'd0);
    check("rst_din", 32'(buf_din), 32'd0);
    check("rst_cursor", 32'({cursor_x, cursor_y}), 32'd0);
    check("rst_first_line", 32'(first_line), 32'd0);
    check("rst_ready", 32'(in_ready), 32'd1);
    check("rst_busy", 32'(busy), 32'd0);

    for (int v = 0; v < 12; v++) begin
      send(vecs[v].data);
      check("vec_we", 32'(buf_we), 32'(vecs[v].we));
      if (vecs[v].we) begin
        check("vec_addr", 32'(buf_addr), 32'(vecs[v].addr));
        check("vec_din", 32'(buf_din), 32'(vecs[v].din));
      end
      wait_idle(cyc);
      check("vec_busy_cycles", 32'(cyc), 32'(vecs[v].we));
      check("vec_x", 32'(cursor_x), 32'(vecs[v].x));
      check("vec_y", 32'(cursor_y), 32'(vecs[v].y));
      check("vec_first_line", 32'(first_line), 32'd0);
    end

    // 64 printables with in_valid held through busy cycles; wrap to next row, no scroll.
    send_idle(8'h0D);
    in_data = 8'h42; in_valid = 1'b1; acc = 0; wes = 0; last = '0;
    for (int c = 0; c < 400 && (acc < 64 || !in_ready); c++) begin
      if (in_ready && in_valid) acc++;
      @(posedge clk); #1;
      if (acc == 64) in_valid = 1'b0;
      if (buf_we) begin wes++; last = buf_addr; end
    end
    in_valid = 1'b0;
    check("stream_accepts", 32'(acc), 32'd64);
    check("stream_writes", 32'(wes), 32'd64);
    check("stream_last_addr", 32'(last), 32'h07F);
    check("stream_cursor", 32'({cursor_x, cursor_y}), 32'({6'd0, 4'd2}));
    check("stream_no_clear", 32'(in_ready), 32'd1);

    // Move to (5,3), then BS, BS, CR, LF with no buffer writes.
    send_idle(8'h0A);
    for (int i = 0; i < 5; i++) send_idle(8'h2E);
    check("pos_5_3", 32'({cursor_x, cursor_y}), 32'({6'd5, 4'd3}));
    send(8'h08); check("bs1_we", 32'(buf_we), 32'd0); check("bs1_x", 32'(cursor_x), 32'd4);
    send(8'h08); check("bs2_we", 32'(buf_we), 32'd0); check("bs2_x", 32'(cursor_x), 32'd3);
    send(8'h0D); check("cr_we", 32'(buf_we), 32'd0); check("cr_x", 32'(cursor_x), 32'd0);
    send(8'h0A); check("lf_we", 32'(buf_we), 32'd0); check("lf_y", 32'(cursor_y), 32'd4);

    // Bottom row: LF scrolls and blanks physical row 0.
    for (int i = 0; i < 11; i++) send_idle(8'h0A);
    check("y15", 32'(cursor_y), 32'd15);
    send(8'h0A);
    check("scroll_first_line", 32'(first_line), 32'd1);
    check_clear(4'd0);
    check("scroll_cursor", 32'({cursor_x, cursor_y}), 32'({6'd0, 4'd15}));

    // Scroll to first_line=15, fill to column 63, then wrap-scroll after a write.
    for (int i = 0; i < 14; i++) send_idle(8'h0A);
    check("fl15", 32'(first_line), 32'd15);
    for (int i = 0; i < 63; i++) send_idle(8'h2E);
    check("x63", 32'(cursor_x), 32'd63);
    send(8'h5A);
    check("wrap_we", 32'(buf_we), 32'd1);
    check("wrap_addr", 32'(buf_addr), 32'h3BF);
    check("wrap_din", 32'(buf_din), 32'h5A);
    check("wrap_ready", 32'(in_ready), 32'd0);
    @(posedge clk); #1;
    check("wrap_first_line", 32'(first_line), 32'd0);
    check_clear(4'd15);
    check("wrap_cursor", 32'({cursor_x, cursor_y}), 32'({6'd0, 4'd15}));

    // Reset in the middle of a row clear.
    send(8'h0A);
    repeat (20) begin @(posedge clk); #1; end
    check("mid_clear_addr", 32'(buf_addr), 32'h014);
    check("mid_clear_we", 32'(buf_we), 32'd1);
    rst_n = 1'b0; #1;
    check("abort_we", 32'(buf_we), 32'd0);
    check("abort_first_line", 32'(first_line), 32'd0);
    check("abort_cursor", 32'({cursor_x, cursor_y}), 32'd0);
    check("abort_addr", 32'(buf_addr), 32'd0);
    #3 rst_n = 1'b1;
    @(posedge clk); #1;
    check("post_rst_ready", 32'(in_ready), 32'd1);
    check("post_rst_we", 32'(buf_we), 32'd0);

    send_idle(8'h41);
    send_idle(8'h0A);
    check("pre_ff_cursor", 32'({cursor_x, cursor_y}), 32'({6'd1, 4'd1}));
`ifdef CHAR_WRITER_FF_CLEAR_EN
    send(8'h0C);
    check("ff_cursor", 32'({cursor_x, cursor_y}), 32'd0);
    check("ff_first_line", 32'(first_line), 32'd0);
    wes = 0; acc = 0;
    for (int i = 0; i < 1024; i++) begin
      if (buf_we === 1'b1 && buf_addr === 10'(i) && buf_din === 8'h20 && in_ready === 1'b0) wes++;
      else acc++;
      @(posedge clk); #1;
    end
    check("ff_good_writes", 32'(wes), 32'd1024);
    check("ff_bad_cycles", 32'(acc), 32'd0);
    check("ff_end_we", 32'(buf_we), 32'd0);
    check("ff_end_ready", 32'(in_ready), 32'd1);
`else
    send(8'h0C);
    check("ff_ignored_we", 32'(buf_we), 32'd0);
    check("ff_ignored_ready", 32'(in_ready), 32'd1);
    check("ff_ignored_cursor", 32'({cursor_x, cursor_y}), 32'({6'd1, 4'd1}));
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
